// File: rtl/mem_bus_arbiter.sv
// Round-robin front end that shares one active-low memory port
// among NUM_MASTERS single-transaction req/gnt/done requesters.
module mem_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 256,
    parameter int READ_LAT    = 1
) (
    input  logic                          Clk,
    input  logic                          nReset,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS-1:0]        m_wr,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]        m_gnt,
    output logic [NUM_MASTERS-1:0]        m_done,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [ADDR_W-1:0]             address,
    output logic                          nRead,
    output logic                          nWrite,
    output logic [DATA_W-1:0]             DataOut,
    input  logic [DATA_W-1:0]             DataIn
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } stateT;

    stateT state;
    stateT stateNext;

    logic [IDX_W-1:0]       rrPtr;
    logic [IDX_W-1:0]       rrPtrNext;
    logic [IDX_W-1:0]       winIdx;
    logic [IDX_W-1:0]       winIdxNext;
    logic [IDX_W-1:0]       pickIdx;
    logic [IDX_W-1:0]       scanIdx;
    logic                   pickValid;
    logic                   isWrite;
    logic                   isWriteNext;
    logic [3:0]             latCnt;
    logic [3:0]             latCntNext;
    logic [NUM_MASTERS-1:0] gntNext;
    logic [NUM_MASTERS-1:0] doneNext;
    logic [DATA_W-1:0]      rdataNext;
    logic [DATA_W-1:0]      dataOutNext;
    logic [ADDR_W-1:0]      addrNext;
    logic                   nReadNext;
    logic                   nWriteNext;

    function automatic logic [IDX_W-1:0] wrapInc(input logic [IDX_W-1:0] v);
        if (int'(v) >= NUM_MASTERS - 1)
            return '0;
        return v + 1'b1;
    endfunction

    // First requester at or after rrPtr, wrapping modulo NUM_MASTERS
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = rrPtr;
        scanIdx   = rrPtr;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!pickValid && m_req[scanIdx]) begin
                pickValid = 1'b1;
                pickIdx   = scanIdx;
            end
            scanIdx = wrapInc(scanIdx);
        end
    end

    always_comb begin
        stateNext   = state;
        rrPtrNext   = rrPtr;
        winIdxNext  = winIdx;
        isWriteNext = isWrite;
        latCntNext  = latCnt;
        gntNext     = m_gnt;
        doneNext    = '0;
        rdataNext   = m_rdata;
        addrNext    = address;
        nReadNext   = 1'b1;
        nWriteNext  = 1'b1;
        dataOutNext = '0;
        unique case (state)
            IDLE: begin
                if (pickValid) begin
                    stateNext        = ACCESS;
                    winIdxNext       = pickIdx;
                    isWriteNext      = m_wr[pickIdx];
                    latCntNext       = '0;
                    gntNext          = '0;
                    gntNext[pickIdx] = 1'b1;
                    addrNext = m_addr[int'(pickIdx)*ADDR_W +: ADDR_W];
                    if (m_wr[pickIdx]) begin
                        nWriteNext  = 1'b0;
                        dataOutNext = m_wdata[int'(pickIdx)*DATA_W +: DATA_W];
                    end else begin
                        nReadNext = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (isWrite) begin
                    stateNext        = DONE;
                    doneNext[winIdx] = 1'b1;
                end else if (latCnt == 4'(READ_LAT - 1)) begin
                    stateNext        = DONE;
                    doneNext[winIdx] = 1'b1;
                    rdataNext        = DataIn;
                end else begin
                    latCntNext = latCnt + 4'd1;
                    nReadNext  = 1'b0;
                end
            end
            DONE: begin
                stateNext = IDLE;
                gntNext   = '0;
                rrPtrNext = wrapInc(winIdx);
                addrNext  = '0;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state   <= IDLE;
            rrPtr   <= '0;
            winIdx  <= '0;
            isWrite <= 1'b0;
            latCnt  <= '0;
            m_gnt   <= '0;
            m_done  <= '0;
            m_rdata <= '0;
            address <= '0;
            nRead   <= 1'b1;
            nWrite  <= 1'b1;
            DataOut <= '0;
        end else begin
            state   <= stateNext;
            rrPtr   <= rrPtrNext;
            winIdx  <= winIdxNext;
            isWrite <= isWriteNext;
            latCnt  <= latCntNext;
            m_gnt   <= gntNext;
            m_done  <= doneNext;
            m_rdata <= rdataNext;
            address <= addrNext;
            nRead   <= nReadNext;
            nWrite  <= nWriteNext;
            DataOut <= dataOutNext;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_bus_arbiter;

    localparam int NM = 4;
    localparam int AW = 16;
    localparam int DW = 256;
    localparam int RL = 3;

    logic             Clk;
    logic             nReset;
    logic [NM-1:0]    m_req;
    logic [NM-1:0]    m_wr;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wdata;
    logic [NM-1:0]    m_gnt;
    logic [NM-1:0]    m_done;
    logic [DW-1:0]    m_rdata;
    logic [AW-1:0]    address;
    logic             nRead;
    logic             nWrite;
    logic [DW-1:0]    DataOut;
    logic [DW-1:0]    DataIn;

    int total  = 0;
    int passed = 0;

    mem_bus_arbiter #(
        .NUM_MASTERS(NM),
        .ADDR_W(AW),
        .DATA_W(DW),
        .READ_LAT(RL)
    ) dut (
        .Clk(Clk),
        .nReset(nReset),
        .m_req(m_req),
        .m_wr(m_wr),
        .m_addr(m_addr),
        .m_wdata(m_wdata),
        .m_gnt(m_gnt),
        .m_done(m_done),
        .m_rdata(m_rdata),
        .address(address),
        .nRead(nRead),
        .nWrite(nWrite),
        .DataOut(DataOut),
        .DataIn(DataIn)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string nm, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        total++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
    endtask

    // Transaction model: mK counts cycles since the grant edge
    bit            armed = 1'b0;
    bit            mBusy;
    int            mK;
    int            mW;
    bit            mWr;
    int            mRr;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mData;
    logic [DW-1:0] mRdata;

    always @(posedge Clk) begin : model
        int w;
        int lat;
        if (!nReset) begin
            armed  <= 1'b1;
            mBusy  <= 1'b0;
            mK     <= 0;
            mRr    <= 0;
            mRdata <= '0;
        end else if (!mBusy) begin
            w = -1;
            for (int i = 0; i < NM; i++)
                if (w < 0 && m_req[(mRr + i) % NM] === 1'b1)
                    w = (mRr + i) % NM;
            if (w >= 0) begin
                mBusy <= 1'b1;
                mK    <= 1;
                mW    <= w;
                mWr   <= m_wr[w];
                mAddr <= m_addr[w*AW +: AW];
                mData <= m_wdata[w*DW +: DW];
            end
        end else begin
            lat = mWr ? 1 : RL;
            if (mK == lat + 1) begin
                mBusy <= 1'b0;
                mRr   <= (mW + 1) % NM;
            end else begin
                mK <= mK + 1;
                if (!mWr && mK == lat)
                    mRdata <= DataIn;
            end
        end
    end

    always @(negedge Clk) begin : compare
        int            lat;
        bit            act;
        logic [NM-1:0] expG;
        logic [NM-1:0] expD;
        if (armed) begin
            lat  = mWr ? 1 : RL;
            act  = mBusy && mK <= lat;
            expG = mBusy ? NM'(1 << mW) : '0;
            expD = (mBusy && mK == lat + 1) ? NM'(1 << mW) : '0;
            check("gnt", m_gnt, expG);
            check("done", m_done, expD);
            check("nRead", nRead, !(act && !mWr));
            check("nWrite", nWrite, !(act && mWr));
            check("DataOut", DataOut, (act && mWr) ? mData : '0);
            check("rdata", m_rdata, mRdata);
            if (act)
                check("address", address, mAddr);
        end
    end

    int        gntLog[$];
    logic [NM-1:0] prevGnt = '0;

    always @(negedge Clk) begin : gntMon
        if (m_gnt != '0 && prevGnt == '0)
            for (int i = 0; i < NM; i++)
                if (m_gnt[i])
                    gntLog.push_back(i);
        prevGnt <= m_gnt;
    end

    task automatic setMaster(input int i, input bit wr,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_wr[i]             = wr;
        m_addr[i*AW +: AW]  = a;
        m_wdata[i*DW +: DW] = d;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    int expOrd[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin : stim
        int nGnt0;
        nReset  = 1'b0;
        m_req   = '0;
        m_wr    = '0;
        m_addr  = '0;
        m_wdata = '0;
        DataIn  = '0;
        repeat (3) @(negedge Clk);
        check("rst_gnt", m_gnt, 0);
        check("rst_strobes", {nRead, nWrite}, 2'b11);
        nReset = 1'b1;
        repeat (10) @(negedge Clk);
        check("idle_addr", address, 0);
        check("idle_rdata", m_rdata, 0);

        // master 0 write
        setMaster(0, 1'b1, 16'h1000, {32{8'hA5}});
        m_req = 4'b0001;
        @(negedge Clk);
        m_req = '0;
        check("wr_nWrite", nWrite, 0);
        check("wr_addr", address, 16'h1000);
        check("wr_data", DataOut, {32{8'hA5}});
        @(negedge Clk);
        check("wr_done", m_done, 4'b0001);
        check("wr_nRead", nRead, 1);
        @(negedge Clk);

        // master 1 read, RL=3
        setMaster(1, 1'b0, 16'h0004, '0);
        DataIn = 256'h1234;
        m_req  = 4'b0010;
        for (int c = 1; c <= RL; c++) begin
            @(negedge Clk);
            m_req = '0;
            check("rd_nRead", nRead, 0);
        end
        @(negedge Clk);
        check("rd_done", m_done, 4'b0010);
        check("rd_data", m_rdata, 256'h1234);
        DataIn = '0;
        @(negedge Clk);

        // all four requesting from a fresh rr pointer
        nReset = 1'b0;
        @(negedge Clk);
        nReset = 1'b1;
        gntLog.delete();
        for (int i = 0; i < NM; i++)
            setMaster(i, (i % 2) == 0, AW'(16'h0100 + i), {8{32'(i + 1)}});
        m_req = 4'hF;
        for (int c = 0; c < 300 && gntLog.size() < 8; c++) begin
            DataIn = {8{$urandom}};
            @(negedge Clk);
        end
        check("rr_count", gntLog.size() >= 8, 1);
        for (int i = 0; i < 8; i++)
            if (i < gntLog.size())
                check("rr_order", gntLog[i], expOrd[i]);
        m_req = '0;
        repeat (8) @(negedge Clk);

        // reset during a read access
        setMaster(2, 1'b0, 16'h0222, '0);
        DataIn = 256'hBEEF;
        m_req  = 4'b0100;
        @(negedge Clk);
        @(negedge Clk);
        nReset = 1'b0;
        @(negedge Clk);
        check("abort_strobes", {nRead, nWrite}, 2'b11);
        check("abort_gnt", m_gnt, 0);
        check("abort_done", m_done, 0);
        check("abort_rdata", m_rdata, 0);
        nReset = 1'b1;
        m_req  = '0;
        repeat (6) @(negedge Clk);

        // master 0 withdraws while busy; master 1 must win
        gntLog.delete();
        setMaster(2, 1'b1, 16'h0333, {8{32'hCAFE0002}});
        setMaster(0, 1'b0, 16'h0010, '0);
        setMaster(1, 1'b0, 16'h0011, '0);
        m_req = 4'b0100;
        @(negedge Clk);
        m_req = 4'b0011;
        @(negedge Clk);
        m_req = 4'b0010;
        @(negedge Clk);
        @(negedge Clk);
        check("drop_gnt1", m_gnt, 4'b0010);
        m_req = '0;
        repeat (6) @(negedge Clk);
        nGnt0 = 0;
        foreach (gntLog[i])
            if (gntLog[i] == 0)
                nGnt0++;
        check("drop_no_gnt0", nGnt0, 0);
        check("drop_log_len", gntLog.size(), 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
